// File: rtl/aes_pkg.sv
// Shared AES constants, controller encodings and GF(2^8) helpers used by the
// cipher round blocks and the key memory.
package aes_pkg;

   localparam logic       AES_128_BIT_KEY = 1'b0;
   localparam logic       AES_256_BIT_KEY = 1'b1;
   localparam logic [3:0] AES128_ROUNDS   = 4'ha;
   localparam logic [3:0] AES256_ROUNDS   = 4'he;

   typedef enum logic [1:0] {
      CTRL_IDLE = 2'd0,
      CTRL_INIT = 2'd1,
      CTRL_SBOX = 2'd2,
      CTRL_MAIN = 2'd3
   } ctrl_e;

   typedef enum logic [2:0] {
      UPD_NONE  = 3'd0,
      UPD_INIT  = 3'd1,
      UPD_SBOX  = 3'd2,
      UPD_MAIN  = 3'd3,
      UPD_FINAL = 3'd4
   } upd_e;

   function automatic logic [7:0] gm2(input logic [7:0] op);
      return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] op);
      return gm2(op) ^ op;
   endfunction

   function automatic logic [7:0] gm4(input logic [7:0] op);
      return gm2(gm2(op));
   endfunction

   function automatic logic [7:0] gm8(input logic [7:0] op);
      return gm2(gm4(op));
   endfunction

   function automatic logic [7:0] gm09(input logic [7:0] op);
      return gm8(op) ^ op;
   endfunction

   function automatic logic [7:0] gm11(input logic [7:0] op);
      return gm8(op) ^ gm2(op) ^ op;
   endfunction

   function automatic logic [7:0] gm13(input logic [7:0] op);
      return gm8(op) ^ gm4(op) ^ op;
   endfunction

   function automatic logic [7:0] gm14(input logic [7:0] op);
      return gm8(op) ^ gm4(op) ^ gm2(op);
   endfunction

   function automatic logic [31:0] inv_mixw(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      b0 = w[31:24];
      b1 = w[23:16];
      b2 = w[15:8];
      b3 = w[7:0];
      return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm09(b3),
              gm09(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
              gm13(b0) ^ gm09(b1) ^ gm14(b2) ^ gm11(b3),
              gm11(b0) ^ gm13(b1) ^ gm09(b2) ^ gm14(b3)};
   endfunction

   function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
      return {inv_mixw(s[127:96]), inv_mixw(s[95:64]),
              inv_mixw(s[63:32]),  inv_mixw(s[31:0])};
   endfunction

   // Row r of the column-major state moves right by r columns.
   function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
      logic [31:0] w0, w1, w2, w3;
      w0 = s[127:96];
      w1 = s[95:64];
      w2 = s[63:32];
      w3 = s[31:0];
      return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
              w1[31:24], w0[23:16], w3[15:8], w2[7:0],
              w2[31:24], w1[23:16], w0[15:8], w3[7:0],
              w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc, sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = gm2(sh);
      end
      return acc;
   endfunction

   // x^254 is the multiplicative inverse and maps 0 to 0 without a special case.
   function automatic logic [7:0] gf_inv(input logic [7:0] op);
      logic [7:0] p, r;
      p = op;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] inv_sbox_byte(input logic [7:0] s);
      logic [7:0] b;
      b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

endpackage

// File: rtl/aes_decipher_block_if.sv
// Handshake and data bus between the core, the key memory and the decipher block.
interface aes_decipher_block_if;
   logic         next;
   logic         keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   modport master (
      output next, keylen, round_key, block,
      input  round, new_block, ready
   );

   modport slave (
      input  next, keylen, round_key, block,
      output round, new_block, ready
   );
endinterface

// File: rtl/aes_inv_sbox.sv
// Inverse S-box for one 32-bit word: four independent combinational byte lookups.
module aes_inv_sbox
   import aes_pkg::*;
(
   input  logic [31:0] sword_i,
   output logic [31:0] new_sword_o
);

   for (genvar i = 0; i < 4; i++) begin : g_byte
      assign new_sword_o[8*i +: 8] = inv_sbox_byte(sword_i[8*i +: 8]);
   end

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES inverse cipher: one word of InvSubBytes per cycle, round key
// fetched by the round index this block presents.
module aes_decipher_block
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   aes_decipher_block_if.slave  dec_if
);

   ctrl_e             ctrl_q, ctrl_d;
   upd_e              upd;
   logic [0:3][31:0]  state_q, state_d;
   logic [3:0]        round_ctr_q, round_ctr_d;
   logic [1:0]        sword_ctr_q, sword_ctr_d;
   logic              ready_q, ready_d;
   logic [31:0]       sbox_in, sbox_out;
   logic [127:0]      keyed;

   assign sbox_in = state_q[sword_ctr_q];
   assign keyed   = state_q ^ dec_if.round_key;

   aes_inv_sbox u_inv_sbox (
      .sword_i     (sbox_in),
      .new_sword_o (sbox_out)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q      <= CTRL_IDLE;
         state_q     <= '0;
         round_ctr_q <= 4'd0;
         sword_ctr_q <= 2'd0;
         ready_q     <= 1'b1;
      end else begin
         ctrl_q      <= ctrl_d;
         state_q     <= state_d;
         round_ctr_q <= round_ctr_d;
         sword_ctr_q <= sword_ctr_d;
         ready_q     <= ready_d;
      end
   end

   always_comb begin
      ctrl_d = ctrl_q;
      case (ctrl_q)
         CTRL_IDLE: if (dec_if.next) ctrl_d = CTRL_INIT;
         CTRL_INIT: ctrl_d = CTRL_SBOX;
         CTRL_SBOX: if (sword_ctr_q == 2'd3) ctrl_d = CTRL_MAIN;
         CTRL_MAIN: ctrl_d = (round_ctr_q != 4'd0) ? CTRL_SBOX : CTRL_IDLE;
         default:   ctrl_d = CTRL_IDLE;
      endcase
   end

   // Counter and ready control; round 0 stays presented through the final key add.
   always_comb begin
      upd         = UPD_NONE;
      round_ctr_d = round_ctr_q;
      sword_ctr_d = sword_ctr_q;
      ready_d     = ready_q;
      case (ctrl_q)
         CTRL_IDLE: begin
            if (dec_if.next) begin
               round_ctr_d = (dec_if.keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
               ready_d     = 1'b0;
            end
         end
         CTRL_INIT: begin
            upd         = UPD_INIT;
            round_ctr_d = round_ctr_q - 4'd1;
            sword_ctr_d = 2'd0;
         end
         CTRL_SBOX: begin
            upd         = UPD_SBOX;
            sword_ctr_d = sword_ctr_q + 2'd1;
         end
         CTRL_MAIN: begin
            if (round_ctr_q != 4'd0) begin
               upd         = UPD_MAIN;
               round_ctr_d = round_ctr_q - 4'd1;
               sword_ctr_d = 2'd0;
            end else begin
               upd     = UPD_FINAL;
               ready_d = 1'b1;
            end
         end
         default: upd = UPD_NONE;
      endcase
   end

   // InvShiftRows commutes with InvSubBytes, so it is folded into the key-add rounds.
   always_comb begin
      state_d = state_q;
      case (upd)
         UPD_INIT:  state_d = inv_shiftrows(dec_if.block ^ dec_if.round_key);
         UPD_SBOX:  state_d[sword_ctr_q] = sbox_out;
         UPD_MAIN:  state_d = inv_shiftrows(inv_mixcolumns(keyed));
         UPD_FINAL: state_d = keyed;
         default:   state_d = state_q;
      endcase
   end

   assign dec_if.round     = round_ctr_q;
   assign dec_if.new_block = state_q;
   assign dec_if.ready     = ready_q;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Self-checking bench: FIPS-197 vectors, disturbance cases and random loopback
// against a byte-matrix AES model with its own key expansion.
module tb_aes_decipher_block;

   typedef logic [0:15][7:0] st_t;

   localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam int           LOOPS = 300;

   logic clk;
   logic reset_n;
   aes_decipher_block_if dif();

   logic [127:0] rk_mem [0:14];
   logic [7:0]   sbox_t  [256];
   logic [7:0]   isbox_t [256];
   logic [3:0]   trace_q [$];
   int checks;
   int errors;

   assign dif.round_key = rk_mem[dif.round];

   aes_decipher_block dut (
      .clk     (clk),
      .reset_n (reset_n),
      .dec_if  (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = xt(a);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b};
      return d[15-n -: 8];
   endfunction

   task automatic build_tables();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox_t[x]  = s;
         isbox_t[s] = 8'(x);
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   task automatic load_keys(input logic [255:0] key, input logic kl);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int nk, nr;
      nk = kl ? 8 : 4;
      nr = kl ? 14 : 10;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 15; r++)
         rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
   endtask

   function automatic st_t sub_b(input st_t s, input bit inv);
      st_t o;
      for (int i = 0; i < 16; i++) o[i] = inv ? isbox_t[s[i]] : sbox_t[s[i]];
      return o;
   endfunction

   function automatic st_t shift_r(input st_t s, input bit inv);
      st_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[4*c+r] = inv ? s[4*((c-r+4)%4)+r] : s[4*((c+r)%4)+r];
      return o;
   endfunction

   function automatic st_t mix_c(input st_t s, input bit inv);
      st_t o;
      logic [7:0] cf [4];
      logic [7:0] acc;
      cf[0] = inv ? 8'd14 : 8'd2;
      cf[1] = inv ? 8'd11 : 8'd3;
      cf[2] = inv ? 8'd13 : 8'd1;
      cf[3] = inv ? 8'd9  : 8'd1;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(cf[(k-r+4)%4], s[4*c+k]);
            o[4*c+r] = acc;
         end
      return o;
   endfunction

   function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int nr);
      st_t s;
      s = pt ^ rk_mem[0];
      for (int r = 1; r <= nr; r++) begin
         s = shift_r(sub_b(s, 1'b0), 1'b0);
         if (r < nr) s = mix_c(s, 1'b0);
         s = s ^ rk_mem[r];
      end
      return s;
   endfunction

   function automatic logic [127:0] ref_dec(input logic [127:0] ct, input int nr);
      st_t s;
      s = ct ^ rk_mem[nr];
      for (int r = nr - 1; r >= 0; r--) begin
         s = sub_b(shift_r(s, 1'b1), 1'b1);
         s = s ^ rk_mem[r];
         if (r > 0) s = mix_c(s, 1'b1);
      end
      return s;
   endfunction

   // ---------------- stimulus ----------------
   // lat counts edges starting with the one that samples next (that edge is 1).
   task automatic do_op(input logic [127:0] ct, input logic kl, input int disturb_at,
                        input int reset_at, output logic [127:0] res, output int lat);
      @(negedge clk);
      dif.block  = ct;
      dif.keylen = kl;
      dif.next   = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      dif.next = 1'b0;
      trace_q.delete();
      trace_q.push_back(dif.round);
      while (!dif.ready && lat < 200) begin
         if (lat == disturb_at) begin
            dif.next   = 1'b1;
            dif.keylen = ~kl;
         end else if (lat == disturb_at + 1) begin
            dif.next = 1'b0;
         end
         if (lat == reset_at) begin
            reset_n = 1'b0;
            res = '0;
            lat = -1;
            return;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (dif.round != trace_q[$]) trace_q.push_back(dif.round);
      end
      res = dif.new_block;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (dif.ready !== 1'b1) $display("FAIL reset_ready got %b want 1", dif.ready);
      if (dif.ready !== 1'b1) errors++;
      checks++; if (dif.new_block !== 128'h0) begin errors++; $display("FAIL reset_block got %h want 0", dif.new_block); end
      checks++; if (dif.round !== 4'd0) begin errors++; $display("FAIL reset_round got %0d want 0", dif.round); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (dif.ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", dif.ready); end
   endtask

   task automatic test_fips128();
      logic [127:0] res;
      int lat;
      load_keys({K128, 128'h0}, 1'b0);
      do_op(CT128, 1'b0, -1, -1, res, lat);
      checks++; if (res !== PT) begin errors++; $display("FAIL fips128_result got %h want %h", res, PT); end
      checks++; if (lat !== 52) begin errors++; $display("FAIL fips128_latency got %0d want 52", lat); end
      checks++; if (dif.round !== 4'd0) begin errors++; $display("FAIL fips128_round_end got %0d want 0", dif.round); end
   endtask

   task automatic test_fips256();
      logic [127:0] res;
      int lat;
      load_keys(K256, 1'b1);
      do_op(CT256, 1'b1, -1, -1, res, lat);
      checks++; if (res !== PT) begin errors++; $display("FAIL fips256_result got %h want %h", res, PT); end
      checks++; if (lat !== 72) begin errors++; $display("FAIL fips256_latency got %0d want 72", lat); end
      checks++; if (trace_q.size() !== 15) begin errors++; $display("FAIL fips256_trace_len got %0d want 15", trace_q.size()); end
      for (int i = 0; i < trace_q.size() && i < 15; i++) begin
         checks++;
         if (trace_q[i] !== 4'(14 - i)) begin
            errors++;
            $display("FAIL fips256_trace[%0d] got %0d want %0d", i, trace_q[i], 14 - i);
         end
      end
   endtask

   task automatic test_ignore_next();
      logic [127:0] res;
      int lat;
      load_keys({K128, 128'h0}, 1'b0);
      do_op(CT128, 1'b0, 10, -1, res, lat);
      checks++; if (res !== PT) begin errors++; $display("FAIL ignore_next_result got %h want %h", res, PT); end
      checks++; if (lat !== 52) begin errors++; $display("FAIL ignore_next_latency got %0d want 52", lat); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] res;
      int lat;
      load_keys(K256, 1'b1);
      do_op(CT256, 1'b1, -1, 20, res, lat);
      #1;
      checks++; if (dif.ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", dif.ready); end
      checks++; if (dif.new_block !== 128'h0) begin errors++; $display("FAIL midreset_block got %h want 0", dif.new_block); end
      checks++; if (dif.round !== 4'd0) begin errors++; $display("FAIL midreset_round got %0d want 0", dif.round); end
      @(negedge clk);
      reset_n = 1'b1;
      load_keys({K128, 128'h0}, 1'b0);
      do_op(CT128, 1'b0, -1, -1, res, lat);
      checks++; if (res !== PT) begin errors++; $display("FAIL after_reset_result got %h want %h", res, PT); end
      checks++; if (lat !== 52) begin errors++; $display("FAIL after_reset_latency got %0d want 52", lat); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] ct2, exp2;
      int lat;
      load_keys({K128, 128'h0}, 1'b0);
      ct2  = {$urandom, $urandom, $urandom, $urandom};
      exp2 = ref_dec(ct2, 10);
      @(negedge clk);
      dif.block  = CT128;
      dif.keylen = 1'b0;
      dif.next   = 1'b1;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!dif.ready && lat < 200);
      checks++; if (dif.new_block !== PT) begin errors++; $display("FAIL b2b_first got %h want %h", dif.new_block, PT); end
      checks++; if (lat !== 52) begin errors++; $display("FAIL b2b_first_latency got %0d want 52", lat); end
      dif.block = ct2;
      @(posedge clk);
      @(negedge clk);
      checks++; if (dif.ready !== 1'b0) begin errors++; $display("FAIL b2b_restart got ready %b want 0", dif.ready); end
      lat = 1;
      while (!dif.ready && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      dif.next = 1'b0;
      checks++; if (dif.new_block !== exp2) begin errors++; $display("FAIL b2b_second got %h want %h", dif.new_block, exp2); end
      checks++; if (lat !== 52) begin errors++; $display("FAIL b2b_second_latency got %0d want 52", lat); end
   endtask

   task automatic test_loopback();
      logic [255:0] key;
      logic [127:0] pt, ct, res;
      logic         kl;
      int lat, nr;
      for (int k = 0; k < 2; k++) begin
         kl = k[0];
         nr = kl ? 14 : 10;
         for (int n = 0; n < LOOPS; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (!kl) key[127:0] = '0;
            pt = {$urandom, $urandom, $urandom, $urandom};
            load_keys(key, kl);
            ct = ref_enc(pt, nr);
            do_op(ct, kl, -1, -1, res, lat);
            checks++;
            if (res !== pt) begin
               errors++;
               $display("FAIL loopback kl=%0d iter %0d got %h want %h", kl, n, res, pt);
            end
            checks++;
            if (lat !== 2 + 5*nr) begin
               errors++;
               $display("FAIL loopback_latency kl=%0d iter %0d got %0d want %0d", kl, n, lat, 2 + 5*nr);
            end
         end
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset_n    = 1'b0;
      dif.next   = 1'b0;
      dif.keylen = 1'b0;
      dif.block  = '0;
      for (int r = 0; r < 15; r++) rk_mem[r] = '0;
      build_tables();
      test_reset();
      test_fips128();
      test_fips256();
      test_ignore_next();
      test_reset_mid();
      test_back_to_back();
      test_loopback();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog expired after %0d checks", checks);
      $fatal(1, "timeout");
   end

endmodule
